pwm_decoder: RTL

Receive-side counterpart of the board's fixed-frame PWM generator: measures high time and period of an incoming PWM line on the 1 MHz system clock and recovers the 4-bit pulse-width code (high time = code × 100 clocks, frame = 2000 clocks). Sits at the input of any block consuming a PWM command line. Publishes a registered code with a one-cycle valid strobe per accepted frame, and flags frames whose period is out of tolerance or whose line is stuck high.

---
 rtl/pwm_decoder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pwm_decoder.sv
// PWM receive decoder: measures high time and rise-to-rise period of pwm_in and
// recovers the 4-bit width code. Optional glitch filter: define PWM_DECODER_FILTER_EN.
module pwm_decoder #(
  parameter int CLK_PER_PERIOD = 2000,
  parameter int CLK_PER_STEP   = 100,
  parameter int TOL            = 20
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [3:0] pulse_width,
  output logic       pw_valid,
  output logic       period_err,
  output logic       stuck_high,
  output logic [1:0] dbg_state
);

  localparam int T        = CLK_PER_PERIOD + TOL;
  localparam int PW       = $clog2(T + 1);
  localparam int SW       = $clog2(CLK_PER_STEP + 1);
  localparam int PRE      = CLK_PER_STEP / 2 + 1;
  localparam bit PRE_WRAP = (PRE >= CLK_PER_STEP);

  localparam logic [PW-1:0] T_C     = PW'(T);
  localparam logic [PW-1:0] LO_C    = PW'(CLK_PER_PERIOD - TOL - 1);
  localparam logic [PW-1:0] HI_C    = PW'(T - 1);
  localparam logic [SW-1:0] STEP_M1 = SW'(CLK_PER_STEP - 1);
  localparam logic [SW-1:0] PRE_C   = SW'(PRE_WRAP ? 0 : PRE);

  typedef enum logic [1:0] {
    ST_ACQ  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          sync1, sync2, s, d;
  logic          rise, fall;
  logic [PW-1:0] pcnt;
  logic [SW-1:0] ps;
  logic [3:0]    units;
  logic [3:0]    pw_n;
  logic          valid_n, err_n, stuck_n, pcnt_restart;
  logic          in_window;

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_DECODER_FILTER_EN
  logic h1, h2, filt_q;

  // Level follows the line only once three consecutive samples agree.
  assign s = (sync2 == h1 && h1 == h2) ? sync2 : filt_q;

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      h1     <= 1'b0;
      h2     <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      h1     <= sync2;
      h2     <= h1;
      filt_q <= s;
    end
  end
`else
  assign s = sync2;
`endif

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) d <= 1'b0;
    else        d <= s;
  end

  assign rise      = s & ~d;
  assign fall      = ~s & d;
  // pcnt holds period-1 in the cycle of the closing rise.
  assign in_window = (pcnt >= LO_C) && (pcnt <= HI_C);

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n)                    pcnt <= '0;
    else if (rise || pcnt_restart) pcnt <= '0;
    else if (pcnt != T_C)          pcnt <= pcnt + PW'(1);
  end

  // Preload of half a step plus the rise cycle itself gives round-half-up.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      ps    <= '0;
      units <= '0;
    end else if (rise) begin
      ps    <= PRE_C;
      units <= PRE_WRAP ? 4'd1 : 4'd0;
    end else if (state == ST_HIGH && s) begin
      if (ps == STEP_M1) begin
        ps <= '0;
        if (units != 4'hF) units <= units + 4'd1;
      end else begin
        ps <= ps + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACQ;
      pulse_width <= 4'd0;
      pw_valid    <= 1'b0;
      period_err  <= 1'b0;
      stuck_high  <= 1'b0;
    end else begin
      state       <= state_n;
      pulse_width <= pw_n;
      pw_valid    <= valid_n;
      period_err  <= err_n;
      stuck_high  <= stuck_n;
    end
  end

  // pw_valid and period_err are single-cycle strobes with no back-pressure:
  // a consumer must capture pulse_width in the cycle pw_valid is high.
  always_comb begin
    state_n      = state;
    pw_n         = pulse_width;
    valid_n      = 1'b0;
    err_n        = 1'b0;
    stuck_n      = stuck_high;
    pcnt_restart = 1'b0;
    if (rise) stuck_n = 1'b0;
    case (state)
      ST_ACQ: begin
        if (rise) state_n = ST_HIGH;
      end
      ST_HIGH: begin
        if (fall) begin
          state_n = ST_LOW;
        end else if (pcnt == T_C) begin
          stuck_n = 1'b1;
          state_n = ST_ACQ;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_n = ST_HIGH;
          if (in_window) begin
            pw_n    = units;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else if (pcnt == T_C) begin
          pw_n         = 4'd0;
          valid_n      = 1'b1;
          pcnt_restart = 1'b1;
        end
      end
      default: state_n = ST_ACQ;
    endcase
  end

  assign dbg_state = state;

endmodule
